// File: rtl/seq_det_pkg.sv
// Shared defaults, cycle-action encoding and width helper for the serial sequence detector.
package seq_det_pkg;

  localparam int DEF_PAT_W = 6;
  localparam logic [DEF_PAT_W-1:0] DEF_PAT_RST = 6'b101011;
  localparam int DEF_CNT_W = 8;

  // What the detector does in a given cycle, already resolved by priority.
  typedef enum logic [1:0] {
    ACT_IDLE  = 2'd0,
    ACT_SHIFT = 2'd1,
    ACT_LOAD  = 2'd2,
    ACT_CLEAR = 2'd3
  } act_e;

  // Bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_detect_param_shift_window.sv
// Serial shift window with a saturating count of how many valid bits it currently holds.
// window_n/fill_n expose the values the registers take on the coming edge so the
// comparator can decide a match in the same cycle the completing bit arrives.
module shift_window
  import seq_det_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  localparam int FILL_W = clog2(PAT_W + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ser_in,
  input  logic              shift_en,
  input  logic              flush,
  input  logic              disarm,
  output logic [PAT_W-1:0]  window_n,
  output logic [FILL_W-1:0] fill_n,
  output logic [FILL_W-1:0] fill
);

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  window_reg;
  logic [FILL_W-1:0] fill_reg;

  // Next window/fill assuming a shift; fill stops counting once the window is full.
  always_comb begin
    window_n = window_reg;
    fill_n   = fill_reg;
    if (shift_en) begin
      window_n = {window_reg[PAT_W-2:0], ser_in};
      if (fill_reg != FILL_FULL) begin
        fill_n = fill_reg + 1'b1;
      end
    end
  end

  // Flush empties everything; disarm keeps the bits but forces a fresh fill.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      window_reg <= '0;
      fill_reg   <= '0;
    end else if (flush) begin
      window_reg <= '0;
      fill_reg   <= '0;
    end else begin
      window_reg <= window_n;
      fill_reg   <= disarm ? '0 : fill_n;
    end
  end

  assign fill = fill_reg;

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised serial sequence detector: masked pattern compare on a shift window,
// overlapping or non-overlapping detection, registered match pulse and saturating count.
module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W    = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PAT_RST  = DEF_PAT_RST,
  parameter logic [PAT_W-1:0] MASK_RST = '1,
  parameter int               CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic             in_valid,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [PAT_W-1:0] mask_in,
  input  logic             clear,
  output logic             seq_out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             armed
);

  localparam int FILL_W = clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  act_e              act;
  logic              shift_en;
  logic              flush;
  logic              disarm;
  logic              hit;
  logic [PAT_W-1:0]  miss;
  logic [PAT_W-1:0]  window_n;
  logic [FILL_W-1:0] fill_n;
  logic [FILL_W-1:0] fill;

  logic [PAT_W-1:0]  pattern_reg;
  logic [PAT_W-1:0]  mask_reg;
  logic              seq_out_reg;
  logic [CNT_W-1:0]  cnt_reg;

  // Resolve the cycle's action: clear beats load, load beats a shift.
  always_comb begin
    act = ACT_IDLE;
    if (clear) begin
      act = ACT_CLEAR;
    end else if (pat_load) begin
      act = ACT_LOAD;
    end else if (in_valid) begin
      act = ACT_SHIFT;
    end
  end

  assign shift_en = (act == ACT_SHIFT);
  assign flush    = (act == ACT_CLEAR);

  // A bit position mismatches only if it is cared about and differs from the pattern.
  generate
    for (genvar gi = 0; gi < PAT_W; gi++) begin : g_cmp
      assign miss[gi] = mask_reg[gi] & (window_n[gi] ^ pattern_reg[gi]);
    end
  endgenerate

  // Only a full window of genuinely sampled bits may match, so reset zeros never do.
  assign hit = shift_en && (fill_n == FILL_FULL) && (miss == '0);

  // Non-overlapping mode restarts the fill after a hit; a load always restarts it.
  assign disarm = (act == ACT_LOAD) || (hit && !overlap);

  shift_window #(
    .PAT_W(PAT_W)
  ) u_window (
    .clk      (clk),
    .reset    (reset),
    .ser_in   (in),
    .shift_en (shift_en),
    .flush    (flush),
    .disarm   (disarm),
    .window_n (window_n),
    .fill_n   (fill_n),
    .fill     (fill)
  );

  // Pattern and mask registers; a load also happens when it coincides with a clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pattern_reg <= PAT_RST;
      mask_reg    <= MASK_RST;
    end else if (pat_load) begin
      pattern_reg <= pat_in;
      mask_reg    <= mask_in;
    end
  end

  // One-cycle match pulse, raised on the edge that samples the completing bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seq_out_reg <= 1'b0;
    end else begin
      seq_out_reg <= hit;
    end
  end

  // Saturating match counter; clear wins over a coincident hit (which cannot occur anyway).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (flush) begin
      cnt_reg <= '0;
    end else if (hit && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign seq_out   = seq_out_reg;
  assign match_cnt = cnt_reg;
  assign armed     = (fill == FILL_FULL);

endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench for seq_detect_param: a behavioural model predicts every cycle,
// predictions go through a queue and are compared once the DUT has clocked.
module tb_seq_detect_param;

  localparam int PW = 6;
  localparam int CW = 2;
  localparam int CNT_MAX = 3;

  logic          clk;
  logic          reset;
  logic          in_bit;
  logic          in_valid;
  logic          overlap;
  logic          pat_load;
  logic [PW-1:0] pat_in;
  logic [PW-1:0] mask_in;
  logic          clear;
  logic          seq_out;
  logic [CW-1:0] match_cnt;
  logic          armed;

  typedef struct {
    logic          seq;
    logic [CW-1:0] cnt;
    logic          armed;
  } exp_t;

  exp_t sb_q[$];

  int chk_cnt = 0;
  int err_cnt = 0;
  int txn_cnt = 0;

  // behavioural model state
  logic [PW-1:0] m_win;
  logic [PW-1:0] m_pat;
  logic [PW-1:0] m_mask;
  int            m_fill;
  int            m_cnt;

  // per-stream observation
  int          bit_idx;
  logic [31:0] pulse_map;
  int          idle_pulses;

  seq_detect_param #(
    .PAT_W   (PW),
    .PAT_RST (6'b101011),
    .MASK_RST(6'b111111),
    .CNT_W   (CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in       (in_bit),
    .in_valid (in_valid),
    .overlap  (overlap),
    .pat_load (pat_load),
    .pat_in   (pat_in),
    .mask_in  (mask_in),
    .clear    (clear),
    .seq_out  (seq_out),
    .match_cnt(match_cnt),
    .armed    (armed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_win  = '0;
    m_fill = 0;
    m_cnt  = 0;
    m_pat  = 6'b101011;
    m_mask = 6'b111111;
  endtask

  task automatic start_stream();
    bit_idx     = 0;
    pulse_map   = '0;
    idle_pulses = 0;
  endtask

  // One clocked transaction: drive, predict, push; after the edge pop and compare.
  task automatic drive(input string tag, input logic v, input logic b, input logic ld,
                       input logic [PW-1:0] pin, input logic [PW-1:0] min, input logic clr);
    exp_t e;
    logic hit;
    in_valid = v;
    in_bit   = b;
    pat_load = ld;
    pat_in   = pin;
    mask_in  = min;
    clear    = clr;
    hit      = 1'b0;
    if (clr) begin
      m_win  = '0;
      m_fill = 0;
      m_cnt  = 0;
      if (ld) begin
        m_pat  = pin;
        m_mask = min;
      end
    end else if (ld) begin
      m_pat  = pin;
      m_mask = min;
      m_fill = 0;
    end else if (v) begin
      m_win = {m_win[PW-2:0], b};
      if (m_fill < PW) m_fill++;
      if (m_fill == PW && ((m_win ^ m_pat) & m_mask) == '0) begin
        hit = 1'b1;
        if (m_cnt < CNT_MAX) m_cnt++;
        if (!overlap) m_fill = 0;
      end
    end
    e.seq   = hit;
    e.cnt   = m_cnt[CW-1:0];
    e.armed = (m_fill == PW);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({tag, ".seq_out"}, 32'(seq_out), 32'(e.seq));
    check({tag, ".match_cnt"}, 32'(match_cnt), 32'(e.cnt));
    check({tag, ".armed"}, 32'(armed), 32'(e.armed));
    if (v && !clr && !ld) begin
      if (seq_out) pulse_map[bit_idx] = 1'b1;
      bit_idx++;
    end else if (seq_out) begin
      idle_pulses++;
    end
    txn_cnt++;
    $display("txn %0d %s v=%b in=%b ld=%b clr=%b ovl=%b -> seq_out=%b match_cnt=%0d armed=%b",
             txn_cnt, tag, v, b, ld, clr, overlap, seq_out, match_cnt, armed);
  endtask

  // Shift n bits, oldest first, with in_valid held high.
  task automatic stream(input string tag, input logic [31:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      drive(tag, 1'b1, bits[n-1-i], 1'b0, '0, '0, 1'b0);
    end
  endtask

  initial begin
    reset    = 1'b0;
    in_bit   = 1'b0;
    in_valid = 1'b0;
    overlap  = 1'b1;
    pat_load = 1'b0;
    pat_in   = '0;
    mask_in  = '0;
    clear    = 1'b0;
    model_reset();
    start_stream();

    #12;
    check("rst.seq_out", 32'(seq_out), 32'd0);
    check("rst.match_cnt", 32'(match_cnt), 32'd0);
    check("rst.armed", 32'(armed), 32'd0);
    reset = 1'b1;

    // 1: reset pattern detected after the 6th bit
    overlap = 1'b1;
    start_stream();
    stream("t1", 32'b101011, 6);
    check("t1.pulses", pulse_map, 32'h20);
    check("t1.cnt", 32'(match_cnt), 32'd1);

    // 2: all-zero pattern; zeros already in the window do not count
    drive("t2.ldclr", 1'b1, 1'b1, 1'b1, 6'b000000, 6'b111111, 1'b1);
    check("t2.cnt_cleared", 32'(match_cnt), 32'd0);
    start_stream();
    stream("t2", 32'b0000000, 7);
    check("t2.pulses", pulse_map, 32'h60);
    check("t2.cnt", 32'(match_cnt), 32'd2);

    // 3: overlapping vs non-overlapping on 101101
    drive("t3.ld", 1'b1, 1'b0, 1'b1, 6'b101101, 6'b111111, 1'b0);
    check("t3.ld_no_pulse", 32'(seq_out), 32'd0);
    overlap = 1'b1;
    start_stream();
    stream("t3o", 32'b10110110110, 11);
    check("t3.ovl_pulses", pulse_map, 32'h120);
    check("t3.cnt_sat", 32'(match_cnt), 32'd3);
    drive("t3.ld2", 1'b0, 1'b0, 1'b1, 6'b101101, 6'b111111, 1'b0);
    overlap = 1'b0;
    start_stream();
    stream("t3n", 32'b10110110110, 11);
    check("t3.novl_pulses", pulse_map, 32'h20);

    // 4: masked compare, only the two oldest bits matter
    drive("t4.ld", 1'b1, 1'b1, 1'b1, 6'b100000, 6'b110000, 1'b0);
    overlap = 1'b1;
    start_stream();
    stream("t4a", 32'b101111, 6);
    check("t4.hit_pulses", pulse_map, 32'h20);
    start_stream();
    stream("t4b", 32'b111111, 6);
    check("t4.miss_pulses", pulse_map, 32'h0);

    // 5: gaps in in_valid
    drive("t5.ldclr", 1'b0, 1'b0, 1'b1, 6'b101011, 6'b111111, 1'b1);
    start_stream();
    begin
      logic [5:0] pat5;
      pat5 = 6'b101011;
      for (int i = 5; i >= 0; i--) begin
        drive("t5v", 1'b1, pat5[i], 1'b0, '0, '0, 1'b0);
        drive("t5i", 1'b0, ~pat5[i], 1'b0, '0, '0, 1'b0);
      end
    end
    check("t5.pulses", pulse_map, 32'h20);
    check("t5.idle_pulses", 32'(idle_pulses), 32'd0);

    // 6: counter saturation with mask=0, clear against a completing bit, async reset
    drive("t6.ldclr", 1'b0, 1'b0, 1'b1, 6'b010101, 6'b000000, 1'b1);
    overlap = 1'b1;
    start_stream();
    stream("t6", 32'b1010011100, 10);
    check("t6.pulses", pulse_map, 32'h3E0);
    check("t6.cnt_sat", 32'(match_cnt), 32'd3);
    drive("t6.clr", 1'b1, 1'b1, 1'b0, '0, '0, 1'b1);
    check("t6.clr_seq", 32'(seq_out), 32'd0);
    check("t6.clr_cnt", 32'(match_cnt), 32'd0);
    start_stream();
    stream("t6b", 32'b1100110, 7);
    check("t6.pre_rst_seq", 32'(seq_out), 32'd1);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("t6.async_seq", 32'(seq_out), 32'd0);
    check("t6.async_cnt", 32'(match_cnt), 32'd0);
    check("t6.async_armed", 32'(armed), 32'd0);
    #2;
    reset = 1'b1;

    // reset pattern is back in force after the asynchronous reset
    start_stream();
    stream("t7", 32'b101011, 6);
    check("t7.pulses", pulse_map, 32'h20);
    check("t7.cnt", 32'(match_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
